frame_read_bridge: RTL and testbench
====================================

FRAME_READ_BRIDGE -- requirements
Module: frame_read_bridge

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 25: width of request and memory addresses.
REQ-002 Parameter DEPTH, default 8: request queue entries, power of two, at least 4.
REQ-003 Parameter MAX_OUTSTANDING, default 4: maximum accepted but unreturned memory reads, 1..15.
REQ-004 clk  input  1: single clock; all logic is rising-edge.
REQ-005 reset_n  input  1: reset, asynchronous, active-low.
REQ-006 req_address  input  ADDRESS_WIDTH: frame-buffer byte address of one pixel read.
REQ-007 req_valid  input  1: req_address is valid this cycle; one request per high cycle.
REQ-008 req_full  output  1: queue almost full; requester stops issuing new requests.
REQ-009 rsp_data  output  8: returned pixel byte, in request order.
REQ-010 rsp_valid  output  1: one-cycle strobe qualifying rsp_data; no backpressure.
REQ-011 mem_address  output  ADDRESS_WIDTH: memory read address.
REQ-012 mem_read  output  1: memory read request; held with mem_address until accepted.
REQ-013 mem_waitrequest  input  1: memory stalls the current mem_read.
REQ-014 mem_readdata  input  8: memory read data.
REQ-015 mem_readdatavalid  input  1: mem_readdata valid; returns are in issue order.
REQ-016 overflow_err  output  1: sticky; a request was dropped.
REQ-017 protocol_err  output  1: sticky; mem_readdatavalid arrived with zero outstanding reads.

Function
REQ-018 Queue: DEPTH-entry FIFO with occupancy count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-019 Push: req_valid=1 and count<DEPTH stores req_address; push and pop in the same cycle leave count unchanged.
REQ-020 Drop: req_valid=1 with count==DEPTH stores nothing and sets overflow_err; a simultaneous pop does not rescue the dropped push.
REQ-021 req_full is registered and high when the next-cycle count is >=DEPTH-1, giving one slot of headroom for the requester's one-cycle reaction lag.
REQ-022 FSM IDLE: mem_read=0; moves to ISSUE when the queue is non-empty and outstanding<MAX_OUTSTANDING.
REQ-023 FSM ISSUE: mem_read=1 and mem_address=queue head; mem_address and mem_read are stable while mem_waitrequest=1.
REQ-024 Acceptance in ISSUE: mem_waitrequest=0 pops the head and increments outstanding.
REQ-025 After acceptance, ISSUE stays in ISSUE with the new head when the queue is still non-empty and outstanding+1<MAX_OUTSTANDING; otherwise it returns to IDLE.
REQ-026 Minimum gap between a push into an empty queue and the first mem_read=1 is 1 cycle.
REQ-027 Return: mem_readdatavalid=1 with outstanding>0 decrements outstanding, and the next cycle sets rsp_data=mem_readdata and rsp_valid=1 (latency 1).
REQ-028 mem_readdatavalid=1 with outstanding==0: no rsp_valid, protocol_err set, outstanding stays 0.
REQ-029 Acceptance and return in the same cycle leave outstanding unchanged.
REQ-030 rsp_data holds its last value while rsp_valid=0.

Reset
REQ-031 Asserting reset_n=0 immediately clears the queue, pointers, count and outstanding, and forces FSM=IDLE, mem_read=0, mem_address=0, req_full=0, rsp_valid=0, rsp_data=0, overflow_err=0, protocol_err=0.
REQ-032 Reset mid-transaction discards in-flight reads; memory returns arriving after reset release with outstanding==0 follow REQ-028.
REQ-033 Queue storage RAM needs no reset; only control state is reset.

Structure
REQ-034 Shared package holds the FSM state encoding (IDLE=0, ISSUE=1) and the default parameter constants.
REQ-035 The queue is one sub-module, frb_req_fifo (push, pop, head, count, wrap), instantiated once.

Verification
REQ-036 Single request: address 0x0000A0, zero-wait memory, read latency 3, data 0x5C -> mem_read 1 cycle after push, rsp_valid=1 with 0x5C 4 cycles after acceptance.
REQ-037 Burst: 8 back-to-back requests (DEPTH=8, memory stalled) -> req_full rises once count reaches 7; a 9th push while count==8 sets overflow_err; the first 8 responses return in order.
REQ-038 Waitrequest: mem_waitrequest=1 for 5 cycles -> mem_address and mem_read are unchanged over those cycles, and exactly one pop occurs on release.
REQ-039 Outstanding limit: MAX_OUTSTANDING=4, 6 queued, memory never returns -> exactly 4 acceptances, then IDLE; each return enables exactly one further acceptance.
REQ-040 Stray return: mem_readdatavalid pulse after reset -> rsp_valid stays 0 and protocol_err=1.
REQ-041 Reset with 3 reads outstanding and 2 queued -> all outputs take their reset values in the same cycle, no rsp_valid follows, and the queue is empty.

Source files
------------

// File: rtl/frame_read_bridge_pkg.sv
// Shared FSM encoding and default parameter constants for the frame read bridge.
package frame_read_bridge_pkg;

    localparam int unsigned FRB_ADDRESS_WIDTH   = 25;
    localparam int unsigned FRB_DEPTH           = 8;
    localparam int unsigned FRB_MAX_OUTSTANDING = 4;
    localparam int unsigned FRB_OUTSTANDING_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } frb_state_e;

endpackage

// File: rtl/frame_read_bridge_req_fifo.sv
// Request address queue: DEPTH entries, power-of-two wrap, occupancy 0..DEPTH.
module frb_req_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != (PW+1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (PW+1)'(1);
            else if (!do_push && do_pop) count_q <= count_q - (PW+1)'(1);
        end
    end

    // Storage is plain RAM; only the control state above is reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/frame_read_bridge.sv
// Pixel read bridge: queues byte-address requests, issues ordered memory reads, returns data.
module frame_read_bridge
    import frame_read_bridge_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH   = FRB_ADDRESS_WIDTH,
    parameter int unsigned DEPTH           = FRB_DEPTH,
    parameter int unsigned MAX_OUTSTANDING = FRB_MAX_OUTSTANDING
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic                     req_valid,
    output logic                     req_full,
    output logic [7:0]               rsp_data,
    output logic                     rsp_valid,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_read,
    input  logic                     mem_waitrequest,
    input  logic [7:0]               mem_readdata,
    input  logic                     mem_readdatavalid,
    output logic                     overflow_err,
    output logic                     protocol_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = FRB_OUTSTANDING_W;

    frb_state_e             state_q, state_d;
    logic [OW-1:0]          outst_q, outst_d;
    logic [CW-1:0]          count, count_d;
    logic [ADDRESS_WIDTH-1:0] head;
    logic                   push, pop, ret, stray;
    logic                   req_full_q, rsp_valid_q, overflow_q, protocol_q;
    logic [7:0]             rsp_data_q;

    frb_req_fifo #(
        .WIDTH (ADDRESS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (req_address),
        .head_o  (head),
        .count_o (count)
    );

    assign push  = req_valid && (count != CW'(DEPTH));
    assign pop   = (state_q == ISSUE) && !mem_waitrequest && (count != '0);
    assign ret   = mem_readdatavalid && (outst_q != '0);
    assign stray = mem_readdatavalid && (outst_q == '0);

    always_comb begin
        count_d = count;
        if (push && !pop)      count_d = count + CW'(1);
        else if (!push && pop) count_d = count - CW'(1);
        outst_d = outst_q;
        if (pop && !ret)       outst_d = outst_q + OW'(1);
        else if (!pop && ret)  outst_d = outst_q - OW'(1);
    end

    // IDLE looks at this cycle's push so a request into an empty queue issues next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (((count != '0) || push) && (outst_q < OW'(MAX_OUTSTANDING)))
                    state_d = ISSUE;
            end
            ISSUE: begin
                if (pop && !((count_d != '0) && ((outst_q + OW'(1)) < OW'(MAX_OUTSTANDING))))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            outst_q     <= '0;
            req_full_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            overflow_q  <= 1'b0;
            protocol_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            outst_q     <= outst_d;
            req_full_q  <= (count_d >= CW'(DEPTH - 1));
            rsp_valid_q <= ret;
            if (ret) rsp_data_q <= mem_readdata;
            if (req_valid && !push) overflow_q <= 1'b1;
            if (stray) protocol_q <= 1'b1;
        end
    end

    assign mem_read     = (state_q == ISSUE);
    assign mem_address  = mem_read ? head : '0;
    assign req_full     = req_full_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign overflow_err = overflow_q;
    assign protocol_err = protocol_q;

endmodule

// File: tb/tb_frame_read_bridge.sv
// Directed bench for frame_read_bridge: vector table plus multi-cycle sequences.
module tb_frame_read_bridge;

    logic        clk, reset_n;
    logic [24:0] req_address;
    logic        req_valid;
    logic        req_full;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic [24:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [7:0]  mem_readdata;
    logic        mem_readdatavalid;
    logic        overflow_err;
    logic        protocol_err;

    int tests = 0;
    int fails = 0;
    int acc   = 0;
    int due_q[$];
    logic [7:0] dat_q[$];
    logic [7:0] exp_q[$];

    frame_read_bridge #(
        .ADDRESS_WIDTH   (25),
        .DEPTH           (8),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_address       (req_address),
        .req_valid         (req_valid),
        .req_full          (req_full),
        .rsp_data          (rsp_data),
        .rsp_valid         (rsp_valid),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .overflow_err      (overflow_err),
        .protocol_err      (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        rv;
        logic [24:0] addr;
        logic        wr;
        logic        rdv;
        logic [7:0]  rdata;
        logic        e_read;
        logic [24:0] e_addr;
        logic        e_rv;
        logic [7:0]  e_rd;
        logic        e_full;
        logic        e_perr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = 1'b0; req_address = '0;
        mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic count_acc(input int n);
        for (int i = 0; i < n; i++) begin
            if (mem_read && !mem_waitrequest) acc++;
            step();
        end
    endtask

    // Memory responder: returns the low address byte lat cycles after acceptance.
    task automatic run_mem(input int cycles, input int lat);
        for (int c = 0; c < cycles; c++) begin
            mem_readdatavalid = 1'b0;
            if (due_q.size() != 0 && due_q[0] == c) begin
                mem_readdatavalid = 1'b1;
                mem_readdata = dat_q.pop_front();
                void'(due_q.pop_front());
            end
            if (mem_read && !mem_waitrequest) begin
                due_q.push_back(c + lat);
                dat_q.push_back(mem_address[7:0]);
            end
            step();
            if (rsp_valid) begin
                if (exp_q.size() == 0) check("burst_extra_rsp", 32'(rsp_valid), 32'(0));
                else check("burst_rsp_order", 32'(rsp_data), 32'(exp_q.pop_front()));
            end
        end
        mem_readdatavalid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 25'h0000A0, 1'b0, 1'b0, 8'h00, 1'b1, 25'h0000A0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 25'h000000, 1'b0, 1'b0, 8'h00, 1'b0, 25'h000000, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 25'h000000, 1'b0, 1'b0, 8'h00, 1'b0, 25'h000000, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 25'h000000, 1'b0, 1'b0, 8'h00, 1'b0, 25'h000000, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 25'h000000, 1'b0, 1'b1, 8'h5C, 1'b0, 25'h000000, 1'b1, 8'h5C, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 25'h000000, 1'b0, 1'b0, 8'h00, 1'b0, 25'h000000, 1'b0, 8'h5C, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 25'h000000, 1'b0, 1'b1, 8'h77, 1'b0, 25'h000000, 1'b0, 8'h5C, 1'b0, 1'b1};

        // Reset values, observed while reset is held.
        reset_n = 1'b0;
        req_valid = 1'b0; req_address = '0;
        mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
        #1;
        check("rst_mem_read", 32'(mem_read), 32'(0));
        check("rst_mem_address", 32'(mem_address), 32'(0));
        check("rst_req_full", 32'(req_full), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_data", 32'(rsp_data), 32'(0));
        check("rst_overflow", 32'(overflow_err), 32'(0));
        check("rst_protocol", 32'(protocol_err), 32'(0));

        // Single request with latency-3 memory, then a stray return.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req_valid = vecs[i].rv; req_address = vecs[i].addr;
            mem_waitrequest = vecs[i].wr;
            mem_readdatavalid = vecs[i].rdv; mem_readdata = vecs[i].rdata;
            step();
            check($sformatf("vec%0d_mem_read", i), 32'(mem_read), 32'(vecs[i].e_read));
            check($sformatf("vec%0d_mem_address", i), 32'(mem_address), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
            check($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].e_rd));
            check($sformatf("vec%0d_req_full", i), 32'(req_full), 32'(vecs[i].e_full));
            check($sformatf("vec%0d_protocol_err", i), 32'(protocol_err), 32'(vecs[i].e_perr));
        end
        req_valid = 1'b0; mem_readdatavalid = 1'b0;

        // Burst into a stalled memory, overflow, then ordered drain.
        do_reset();
        mem_waitrequest = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_address = 25'h0001A0 + 25'(i);
            exp_q.push_back(8'hA0 + 8'(i));
            step();
            check($sformatf("burst_req_full_%0d", i), 32'(req_full), 32'((i + 1) >= 7));
            check($sformatf("burst_overflow_%0d", i), 32'(overflow_err), 32'(0));
        end
        req_address = 25'h0001FF;
        step();
        req_valid = 1'b0;
        check("burst_overflow_set", 32'(overflow_err), 32'(1));
        check("burst_stalled_addr", 32'(mem_address), 32'h1A0);
        mem_waitrequest = 1'b0;
        run_mem(100, 2);
        check("burst_all_returned", 32'(exp_q.size()), 32'(0));
        check("burst_req_full_clear", 32'(req_full), 32'(0));

        // Waitrequest holds address and read; one pop per release.
        do_reset();
        mem_waitrequest = 1'b1;
        req_valid = 1'b1; req_address = 25'h000123; step();
        req_address = 25'h000456; step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wait_read_%0d", i), 32'(mem_read), 32'(1));
            check($sformatf("wait_addr_%0d", i), 32'(mem_address), 32'h123);
            step();
        end
        mem_waitrequest = 1'b0; step();
        mem_waitrequest = 1'b1;
        check("wait_next_read", 32'(mem_read), 32'(1));
        check("wait_next_addr", 32'(mem_address), 32'h456);
        step(); step();
        check("wait_hold_addr", 32'(mem_address), 32'h456);
        mem_waitrequest = 1'b0; step();
        check("wait_queue_empty", 32'(mem_read), 32'(0));

        // Outstanding limit of 4 with six queued requests.
        do_reset();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_address = 25'h000400 + 25'(i);
            count_acc(1);
        end
        req_valid = 1'b0;
        count_acc(15);
        check("limit_accepts", 32'(acc), 32'(4));
        check("limit_idle", 32'(mem_read), 32'(0));
        mem_readdatavalid = 1'b1; mem_readdata = 8'h11;
        count_acc(1);
        mem_readdatavalid = 1'b0;
        check("limit_rsp_valid", 32'(rsp_valid), 32'(1));
        count_acc(10);
        check("limit_accepts_r1", 32'(acc), 32'(5));
        mem_readdatavalid = 1'b1; mem_readdata = 8'h22;
        count_acc(1);
        mem_readdatavalid = 1'b0;
        count_acc(10);
        check("limit_accepts_r2", 32'(acc), 32'(6));
        check("limit_final_idle", 32'(mem_read), 32'(0));

        // Asynchronous reset with 3 outstanding and 2 queued.
        do_reset();
        mem_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_address = 25'h000300 + 25'(i); step();
        end
        req_valid = 1'b0;
        mem_waitrequest = 1'b0;
        acc = 0;
        for (int i = 0; i < 20 && acc < 3; i++) count_acc(1);
        check("rst_seq_outstanding", 32'(acc), 32'(3));
        mem_waitrequest = 1'b1;
        req_valid = 1'b1; req_address = 25'h000303; step();
        req_address = 25'h000304; step();
        req_valid = 1'b0;
        check("rst_seq_pending", 32'(mem_read), 32'(1));
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_mem_read", 32'(mem_read), 32'(0));
        check("rst_async_mem_address", 32'(mem_address), 32'(0));
        check("rst_async_req_full", 32'(req_full), 32'(0));
        check("rst_async_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_async_rsp_data", 32'(rsp_data), 32'(0));
        step();
        reset_n = 1'b1;
        mem_waitrequest = 1'b0;
        begin
            logic saw_rv, saw_rd;
            saw_rv = 1'b0; saw_rd = 1'b0;
            for (int i = 0; i < 3; i++) begin
                mem_readdatavalid = 1'b1; mem_readdata = 8'hE0 + 8'(i);
                step();
                mem_readdatavalid = 1'b0;
                if (rsp_valid) saw_rv = 1'b1;
                if (mem_read) saw_rd = 1'b1;
                step();
                if (rsp_valid) saw_rv = 1'b1;
                if (mem_read) saw_rd = 1'b1;
            end
            check("rst_after_no_rsp", 32'(saw_rv), 32'(0));
            check("rst_after_queue_empty", 32'(saw_rd), 32'(0));
        end
        check("rst_after_protocol_err", 32'(protocol_err), 32'(1));
        check("rst_after_overflow", 32'(overflow_err), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
